// File: rtl/vnu_serial.sv
// vnu_serial: serial LDPC variable-node update; exact accumulation of channel LLR
// plus DEG check messages, saturated extrinsic outputs over valid/ready streams.
module vnu_serial #(
    parameter int INT  = 8,
    parameter int FRAC = 8,
    parameter int DEG  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [INT+FRAC-1:0] i_ch_llr,
    input  logic                i_in_valid,
    input  logic [INT+FRAC-1:0] i_in_msg,
    output logic                o_in_ready,
    output logic                o_out_valid,
    output logic [INT+FRAC-1:0] o_out_msg,
    output logic                o_out_last,
    input  logic                i_out_ready,
    output logic [INT+FRAC-1:0] o_belief,
    output logic                o_hard_bit,
    output logic                o_busy
);
    localparam int W  = INT + FRAC;
    localparam int A  = W + $clog2(DEG + 1);
    localparam int IW = $clog2(DEG);
    localparam logic [IW-1:0] LAST = IW'(DEG - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [A-1:0]  r_total;
    logic [W-1:0]  r_buf [DEG];

    logic [IW-1:0] w_nidx;
    logic [A-1:0]  w_sum;
    logic [W-1:0]  w_ext_first;
    logic [W-1:0]  w_ext_next;

    function automatic logic [A-1:0] sext(input logic [W-1:0] x);
        return {{(A-W){x[W-1]}}, x};
    endfunction

    // In range exactly when all bits above the W-bit sign bit agree with it.
    function automatic logic [W-1:0] sat(input logic [A-1:0] x);
        if (&x[A-1:W-1] || ~|x[A-1:W-1]) return x[W-1:0];
        return x[A-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    assign w_nidx      = r_idx + IW'(1);
    assign w_sum       = r_total + sext(i_in_msg);
    assign w_ext_first = sat(w_sum - sext(r_buf[0]));
    assign w_ext_next  = sat(r_total - sext(r_buf[w_nidx]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_total     <= '0;
            o_in_ready  <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_msg   <= '0;
            o_out_last  <= 1'b0;
            o_belief    <= '0;
            o_hard_bit  <= 1'b0;
            o_busy      <= 1'b0;
            for (int i = 0; i < DEG; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_total    <= sext(i_ch_llr);
                    r_idx      <= '0;
                    o_in_ready <= 1'b1;
                    o_busy     <= 1'b1;
                    r_state    <= S_LOAD;
                end
                S_LOAD: if (i_in_valid) begin
                    r_buf[r_idx] <= i_in_msg;
                    r_total      <= w_sum;
                    r_idx        <= (r_idx == LAST) ? '0 : w_nidx;
                    // Final beat: buf[0] is already stored, so the first extrinsic is ready now.
                    if (r_idx == LAST) begin
                        o_in_ready  <= 1'b0;
                        o_out_valid <= 1'b1;
                        o_out_msg   <= w_ext_first;
                        o_out_last  <= 1'b0;
                        o_belief    <= sat(w_sum);
                        o_hard_bit  <= w_sum[A-1];
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: if (i_out_ready) begin
                    if (r_idx == LAST) begin
                        r_idx       <= '0;
                        o_out_valid <= 1'b0;
                        o_out_last  <= 1'b0;
                        o_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_idx      <= w_nidx;
                        o_out_msg  <= w_ext_next;
                        o_out_last <= (w_nidx == LAST);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vnu_serial.sv
// tb_vnu_serial: directed vector table for the 8.8/DEG=3 unit plus corner sequences,
// and random frames on a DEG=6 6.2 instance against a saturating reference model.
module tb_vnu_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    logic        a_start = 0, a_in_valid = 0, a_out_ready = 0;
    logic [15:0] a_ch = 0, a_in_msg = 0;
    logic        a_in_ready, a_out_valid, a_out_last, a_hard_bit, a_busy;
    logic [15:0] a_out_msg, a_belief;

    logic        b_start = 0, b_in_valid = 0, b_out_ready = 0;
    logic [7:0]  b_ch = 0, b_in_msg = 0;
    logic        b_in_ready, b_out_valid, b_out_last, b_hard_bit, b_busy;
    logic [7:0]  b_out_msg, b_belief;

    vnu_serial #(.INT(8), .FRAC(8), .DEG(3)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_ch_llr(a_ch),
        .i_in_valid(a_in_valid), .i_in_msg(a_in_msg), .o_in_ready(a_in_ready),
        .o_out_valid(a_out_valid), .o_out_msg(a_out_msg), .o_out_last(a_out_last),
        .i_out_ready(a_out_ready), .o_belief(a_belief), .o_hard_bit(a_hard_bit),
        .o_busy(a_busy)
    );

    vnu_serial #(.INT(6), .FRAC(2), .DEG(6)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_ch_llr(b_ch),
        .i_in_valid(b_in_valid), .i_in_msg(b_in_msg), .o_in_ready(b_in_ready),
        .o_out_valid(b_out_valid), .o_out_msg(b_out_msg), .o_out_last(b_out_last),
        .i_out_ready(b_out_ready), .o_belief(b_belief), .o_hard_bit(b_hard_bit),
        .o_busy(b_busy)
    );

    typedef struct packed {
        logic [15:0]      ch;
        logic [2:0][15:0] m;
        logic [15:0]      bel;
        logic             hb;
        logic [2:0][15:0] o;
    } vec_t;

    vec_t vt [5];

    function automatic vec_t mk(input logic [15:0] ch, m0, m1, m2, bel, input logic hb,
                                input logic [15:0] o0, o1, o2);
        vec_t v;
        v.ch = ch; v.m[0] = m0; v.m[1] = m1; v.m[2] = m2;
        v.bel = bel; v.hb = hb; v.o[0] = o0; v.o[1] = o1; v.o[2] = o2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "/in_ready"}, a_in_ready, 0);
        chk({tag, "/out_valid"}, a_out_valid, 0);
        chk({tag, "/out_msg"}, a_out_msg, 0);
        chk({tag, "/out_last"}, a_out_last, 0);
        chk({tag, "/belief"}, a_belief, 0);
        chk({tag, "/hard_bit"}, a_hard_bit, 0);
        chk({tag, "/busy"}, a_busy, 0);
    endtask

    // Cycle-exact frame with no bubbles or stalls.
    task automatic frame_a(input vec_t v, input string tag);
        @(negedge clk);
        a_start = 1; a_ch = v.ch;
        @(negedge clk);
        a_start = 0;
        chk({tag, "/in_ready_up"}, a_in_ready, 1);
        chk({tag, "/busy_up"}, a_busy, 1);
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1; a_in_msg = v.m[k];
            @(negedge clk);
        end
        a_in_valid = 0;
        chk({tag, "/in_ready_down"}, a_in_ready, 0);
        chk({tag, "/belief"}, a_belief, v.bel);
        chk({tag, "/hard_bit"}, a_hard_bit, v.hb);
        a_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "/out_valid"}, a_out_valid, 1);
            chk($sformatf("%s/out_msg%0d", tag, k), a_out_msg, v.o[k]);
            chk($sformatf("%s/out_last%0d", tag, k), a_out_last, k == 2);
            @(negedge clk);
        end
        a_out_ready = 0;
        chk({tag, "/out_valid_down"}, a_out_valid, 0);
        chk({tag, "/busy_down"}, a_busy, 0);
    endtask

    // Input bubbles, a 5-cycle output stall on beat 1, stray start pulses while busy.
    task automatic flow_a(input vec_t v);
        int k = 0, j = 0, st = 0, cyc = 0;
        a_in_valid = 1; a_in_msg = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            chk("flow/idle_in_ready", a_in_ready, 0);
        end
        a_in_valid = 0;
        a_start = 1; a_ch = v.ch;
        @(negedge clk);
        while (k < 3 && cyc < 100) begin
            a_start = 1'($urandom_range(0, 1));
            a_in_valid = ($urandom_range(0, 2) != 0);
            a_in_msg = a_in_valid ? v.m[k] : 16'hDEAD;
            if (a_in_valid && a_in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        a_in_valid = 0;
        chk("flow/loaded", k, 3);
        chk("flow/belief", a_belief, v.bel);
        chk("flow/hard_bit", a_hard_bit, v.hb);
        cyc = 0;
        while (j < 3 && cyc < 100) begin
            a_start = 1'($urandom_range(0, 1));
            a_out_ready = !(j == 1 && st < 5);
            if (!a_out_ready) st++;
            chk("flow/out_valid", a_out_valid, 1);
            chk($sformatf("flow/out_msg%0d", j), a_out_msg, v.o[j]);
            chk($sformatf("flow/out_last%0d", j), a_out_last, j == 2);
            if (a_out_ready) j++;
            @(negedge clk);
            cyc++;
        end
        a_start = 0; a_out_ready = 0;
        chk("flow/beats", j, 3);
        chk("flow/stalls", st, 5);
        chk("flow/out_valid_down", a_out_valid, 0);
        chk("flow/busy_down", a_busy, 0);
        @(negedge clk);
        chk("flow/no_restart", a_busy, 0);
    endtask

    function automatic logic [7:0] sat8(input int x);
        return (x > 127) ? 8'h7F : (x < -128) ? 8'h80 : 8'(x);
    endfunction

    function automatic logic [7:0] rnd8();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) ? 8'h7F : 8'h80;
        return 8'($urandom);
    endfunction

    // Back-to-back random frames; each start is raised the cycle busy falls.
    task automatic sweep_b(input int nf);
        for (int f = 0; f < nf; f++) begin
            logic [7:0] m [6];
            logic [7:0] ch;
            int tot, k, j, cyc;
            ch = rnd8();
            tot = int'($signed(ch));
            for (int i = 0; i < 6; i++) begin
                m[i] = rnd8();
                tot += int'($signed(m[i]));
            end
            b_start = 1; b_ch = ch;
            @(negedge clk);
            b_start = 0;
            chk("b/in_ready_up", b_in_ready, 1);
            k = 0; cyc = 0;
            while (k < 6 && cyc < 200) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_msg = b_in_valid ? m[k] : 8'h55;
                if (b_in_valid && b_in_ready) k++;
                @(negedge clk);
                cyc++;
            end
            b_in_valid = 0;
            chk("b/loaded", k, 6);
            j = 0; cyc = 0;
            while (j < 6 && cyc < 200) begin
                b_out_ready = ($urandom_range(0, 2) != 0);
                chk("b/out_valid", b_out_valid, 1);
                if (b_out_ready) begin
                    chk($sformatf("b/f%0d/out_msg%0d", f, j), b_out_msg, sat8(tot - int'($signed(m[j]))));
                    chk($sformatf("b/f%0d/out_last%0d", f, j), b_out_last, j == 5);
                    j++;
                end
                @(negedge clk);
                cyc++;
            end
            b_out_ready = 0;
            chk("b/beats", j, 6);
            chk($sformatf("b/f%0d/belief", f), b_belief, sat8(tot));
            chk($sformatf("b/f%0d/hard_bit", f), b_hard_bit, tot < 0);
            chk("b/busy_down", b_busy, 0);
            chk("b/out_valid_down", b_out_valid, 0);
        end
    endtask

    initial begin
        vt[0] = mk(16'h0100, 16'h0080, 16'hFF00, 16'h0200, 16'h0280, 0, 16'h0200, 16'h0380, 16'h0080);
        vt[1] = mk(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        vt[2] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 16'h8000, 16'h8000, 16'h8000);
        vt[3] = mk(16'hFF00, 16'h0010, 16'h0020, 16'hFFC0, 16'hFEF0, 1, 16'hFEE0, 16'hFED0, 16'hFF30);
        vt[4] = mk(16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h7FFF, 0, 16'h4000, 16'h4000, 16'h7FFF);

        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk_a_reset("reset");
        rst_n = 1;

        for (int i = 0; i < 5; i++) frame_a(vt[i], $sformatf("vec%0d", i));

        flow_a(vt[0]);

        @(negedge clk);
        a_start = 1; a_ch = vt[0].ch;
        @(negedge clk);
        a_start = 0;
        for (int k = 0; k < 2; k++) begin
            a_in_valid = 1; a_in_msg = vt[0].m[k];
            @(negedge clk);
        end
        a_in_valid = 0;
        #1 rst_n = 0;
        #1 chk_a_reset("midreset");
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("postreset/out_valid", a_out_valid, 0);
            chk("postreset/busy", a_busy, 0);
        end
        frame_a(vt[0], "postreset");

        sweep_b(20);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
        $fatal(1);
    end
endmodule

// File: doc/vnu_serial.md
# vnu_serial

Parametrised, serial variable-node update unit for the LDPC decoder. It accepts one channel LLR and DEG check-to-variable messages over a valid/ready stream. It then emits DEG extrinsic variable-to-check messages (total minus own input), plus the saturated a-posteriori belief and a hard decision. It generalises the fixed degree-3 combinational variable node to any degree, with full-precision accumulation, saturation and flow control.

## Interface
- INT, 8, integer bits of the signed two's-complement fixed-point format
- FRAC, 8, fractional bits; W = INT+FRAC
- DEG, 3, variable-node degree; legal range DEG ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  frame start; accepted only in IDLE
- ch_llr  in  W  channel LLR, sampled on accepted start
- in_valid  in  1  check message valid
- in_msg  in  W  check-to-variable message
- in_ready  out  1  high in LOAD only
- out_valid  out  1  extrinsic message valid
- out_msg  out  W  extrinsic variable-to-check message
- out_last  out  1  high with the DEG-th output beat
- out_ready  in  1  downstream accepts out_msg
- belief  out  W  saturated total LLR
- hard_bit  out  1  1 when full-precision total < 0
- busy  out  1  high in LOAD or EMIT

## Operation
- Accumulator width A = W + clog2(DEG+1), signed; all sums exact, no internal overflow.
- Message buffer: DEG × W registers, written in arrival order; index counter of clog2(DEG) bits.
- States:
  - IDLE: start=1 → total ← sext(ch_llr), idx ← 0, go LOAD.
  - LOAD: each in_valid&&in_ready beat → buf[idx] ← in_msg, total += sext(in_msg), idx++. On the DEG-th beat → idx ← 0, go EMIT.
  - EMIT: out_msg = sat(total − sext(buf[idx])). Each out_valid&&out_ready beat → idx++. Last beat (idx = DEG−1) → go IDLE.
- sat(x) clamps to [−2^(W−1), 2^(W−1)−1].
- belief = sat(total); hard_bit = sign of full-precision total. Both update on entry to EMIT and hold until the next EMIT entry; not cleared by start.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; no beat is consumed.
- out_msg and out_last are held stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_msg 0, out_last 0, belief 0, hard_bit 0, busy 0, idx 0, total 0.
- start accepted at edge N → in_ready = 1 and busy = 1 from cycle N+1.
- Last input beat at edge M → in_ready = 0 at M+1; out_valid = 1, belief and hard_bit valid at M+1 (1-cycle latency).
- With out_ready held high, DEG consecutive output beats; out_last on the final one. out_valid = 0 and busy = 0 the cycle after the last handshake.
- Minimum frame period: 1 + DEG + DEG cycles. start may be accepted the cycle busy falls.
- rst_n low mid-frame clears state immediately and asynchronously. The partial frame is discarded and nothing is emitted after release.
- Input bubbles (in_valid low) and output stalls (out_ready low) of any length are legal; no data loss or duplication.

## Test plan
- Nominal, DEG=3, 8.8 format: ch 0x0100; msgs 0x0080, 0xFF00, 0x0200 → belief 0x0280, hard_bit 0, out 0x0200, 0x0380, 0x0080, out_last on third beat.
- Positive saturation: ch 0x7000; msgs 0x7000 ×3 → belief 0x7FFF, all outputs 0x7FFF, hard_bit 0.
- Negative saturation: ch 0x8000; msgs 0x8000 ×3 → belief 0x8000, hard_bit 1, all outputs 0x8000.
- Flow control: random in_valid gaps plus out_ready low for 5 cycles mid-EMIT → out_msg/out_last stable while stalled; same values as nominal; start pulses during busy ignored.
- Reset mid-LOAD after 2 beats → all outputs return to reset values. The next full frame with nominal stimulus produces nominal results.
- Parameter sweep DEG=6, INT=6, FRAC=2: random frames checked against a saturating reference model. Includes back-to-back frames with start asserted the cycle busy falls.
